// File: rtl/pwm_clk_gen.sv
// rtl/pwm_clk_gen.sv - multi-channel programmable clock/PWM generator
//
// Purpose:
//   NUM_CH independent channels. Each channel has a period P and a high time H,
//   both counted in clk_in cycles. Software writes a shadow copy of P/H through
//   load. The shadow is applied only when the channel is halted or at the end of
//   a period, so a reload never produces a runt pulse.
//
// Optional feature:
//   Macro PWM_CLK_GEN_SYNC_EN adds the 1-bit input sync. A sync pulse restarts
//   every running channel at cnt = 0 and applies any pending shadow, as though
//   the period had ended on that cycle.
//
// Ports:
//   clk_in     in   system clock
//   rst        in   synchronous reset, active high
//   sync       in   (PWM_CLK_GEN_SYNC_EN only) phase-align all running channels
//   en         in   [NUM_CH]        per-channel run enable, level
//   load       in   [NUM_CH]        per-channel strobe, captures period/high_time slice
//   period     in   [NUM_CH*CNT_W]  channel i at [i*CNT_W +: CNT_W]
//   high_time  in   [NUM_CH*CNT_W]  channel i at [i*CNT_W +: CNT_W]
//   clk_out    out  [NUM_CH]        generated waveform, registered
//   tick       out  [NUM_CH]        registered pulse marking the first cycle of a period
//   pending    out  [NUM_CH]        shadow holds values not yet applied

module pwm_clk_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk_in,
  input  logic                    rst,
`ifdef PWM_CLK_GEN_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] period,
  input  logic [NUM_CH*CNT_W-1:0] high_time,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  logic sync_req;

`ifdef PWM_CLK_GEN_SYNC_EN
  assign sync_req = sync;
`else
  assign sync_req = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] sper_q;
    logic [CNT_W-1:0] shigh_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;

    logic             run;
    logic             wrap;
    logic             boundary;

    // A period below 2 cannot produce a waveform, so it counts as halted.
    assign run = en[g] && (per_q >= CNT_W'(2));

    // End of the current period: the normal terminal count, or a sync restart.
    assign wrap = run && (sync_req || (cnt_q == per_q - CNT_W'(1)));

    // Points where the shadow may be applied without cutting a period short.
    // A halted channel has no period in flight, so it applies at once.
    assign boundary = !run || wrap;

    always_ff @(posedge clk_in) begin
      if (rst) begin
        per_q   <= '0;
        high_q  <= '0;
        sper_q  <= '0;
        shigh_q <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        // The outputs are one cycle behind cnt. H = 0 gives constant low and
        // H >= P gives constant high without any special-case logic.
        clk_q  <= run && (cnt_q < high_q);
        tick_q <= run && (cnt_q == '0);

        cnt_q <= (run && !wrap) ? cnt_q + CNT_W'(1) : '0;

        // The apply uses the shadow as registered before this cycle. A load on
        // the same cycle lands in the shadow and waits for the next boundary.
        if (boundary && pend_q) begin
          per_q  <= sper_q;
          high_q <= shigh_q;
        end

        if (load[g]) begin
          sper_q  <= period[g*CNT_W +: CNT_W];
          shigh_q <= high_time[g*CNT_W +: CNT_W];
          pend_q  <= 1'b1;
        end else if (boundary) begin
          pend_q  <= 1'b0;
        end
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule
